// File: rtl/write_buffer.sv
// Posted-write FIFO between data cache and memory, with read coherence.
// Define WB_FWD_EN for byte-merge forwarding; otherwise reads drain-stall.
module write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        c_wr_en,
  input  logic [ADDR_W-1:0] c_wr_addr,
  input  logic [DATA_W-1:0] c_wr_data,
  input  logic              c_rd_en,
  input  logic [ADDR_W-1:0] c_rd_addr,
  output logic [DATA_W-1:0] c_rd_data,
  output logic              c_rd_valid,
  output logic              c_rd_busy,
  output logic              c_full,
  output logic              c_empty,
  output logic              c_ovf,
  output logic [7:0]        m_wren,
  output logic [ADDR_W-1:0] m_wraddress,
  output logic [DATA_W-1:0] m_write_data,
  output logic              m_rden,
  output logic [ADDR_W-1:0] m_rdaddress,
  input  logic [DATA_W-1:0] m_read_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = ADDR_W - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  logic [DW-1:0]     r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [7:0]        r_be   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_rd_addr;

  logic          w_wr_req;
  logic          w_enq;
  logic          w_deq;
  logic          w_rd_start;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_wr_dw;
  logic [DW-1:0] w_rd_dw;
  logic          w_unused;

  logic [PW-1:0] w_slot [DEPTH];
  logic          w_live [DEPTH];

  assign w_wr_dw    = c_wr_addr[ADDR_W-1:3];
  assign w_rd_dw    = c_rd_addr[ADDR_W-1:3];
  assign w_unused   = ^{c_wr_addr[2:0], c_rd_addr[2:0]};
  assign w_wr_req   = |c_wr_en;
  assign w_enq      = w_wr_req & ~r_full & ~rst;
  assign w_deq      = ~rst & ~r_empty & (r_state != S_ISSUE);
  assign w_rd_start = (r_state == S_IDLE) & c_rd_en;
  assign w_cnt_nxt  = r_count + CW'(w_enq) - CW'(w_deq);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_slot[g] = r_head + PW'(g);
    assign w_live[g] = CW'(g) < r_count;
  end

`ifdef WB_FWD_EN
  logic [7:0]        r_fmask;
  logic [DATA_W-1:0] r_fdata;
  logic [7:0]        w_fmask;
  logic [DATA_W-1:0] w_fdata;

  // Oldest to newest, so later writes overwrite earlier bytes.
  always_comb begin
    w_fmask = '0;
    w_fdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && r_addr[w_slot[i]] == w_rd_dw) begin
        for (int b = 0; b < 8; b++) begin
          if (r_be[w_slot[i]][b]) begin
            w_fmask[b]          = 1'b1;
            w_fdata[8*b +: 8]   = r_data[w_slot[i]][8*b +: 8];
          end
        end
      end
    end
    if (w_enq && w_wr_dw == w_rd_dw) begin
      for (int b = 0; b < 8; b++) begin
        if (c_wr_en[b]) begin
          w_fmask[b]        = 1'b1;
          w_fdata[8*b +: 8] = c_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fmask <= '0;
      r_fdata <= '0;
    end else if (w_rd_start) begin
      r_fmask <= w_fmask;
      r_fdata <= w_fdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (c_rd_en) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [DATA_W-1:0] w_merged;
  always_comb begin
    w_merged = m_read_data;
    for (int b = 0; b < 8; b++) begin
      if (r_fmask[b]) w_merged[8*b +: 8] = r_fdata[8*b +: 8];
    end
  end
`else
  // r_pend counts entries older than the stalled read.
  logic [CW-1:0] r_pend;
  logic [CW-1:0] w_lim;
  logic [DW-1:0] w_hdw;
  logic          w_hit;
  logic          w_inc_hit;

  assign w_lim     = (r_state == S_DRAIN) ? r_pend : r_count;
  assign w_hdw     = (r_state == S_DRAIN) ? r_rd_addr : w_rd_dw;
  assign w_inc_hit = w_enq & (w_wr_dw == w_rd_dw);

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < w_lim && r_addr[w_slot[i]] == w_hdw)
        w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (w_rd_start) begin
      r_pend <= w_cnt_nxt;
    end else if (r_state == S_DRAIN && w_deq && r_pend != '0) begin
      r_pend <= r_pend - CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (c_rd_en)
          w_next = (w_hit | w_inc_hit) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_IDLE;
      S_DRAIN: if (!w_hit) w_next = S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [DATA_W-1:0] w_merged;
  assign w_merged = m_read_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
      if (w_wr_req && r_full) r_ovf <= 1'b1;
      r_state <= w_next;
      if (w_rd_start) r_rd_addr <= w_rd_dw;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= w_wr_dw;
      r_data[r_tail] <= c_wr_data;
      r_be[r_tail]   <= c_wr_en;
    end
  end

  assign m_wren       = w_deq ? r_be[r_head] : '0;
  assign m_wraddress  = w_deq ? {r_addr[r_head], 3'b000} : '0;
  assign m_write_data = w_deq ? r_data[r_head] : '0;
  assign m_rden       = (r_state == S_ISSUE);
  assign m_rdaddress  = m_rden ? {r_rd_addr, 3'b000} : '0;
  assign c_rd_valid   = (r_state == S_WAIT) & ~rst;
  assign c_rd_data    = c_rd_valid ? w_merged : '0;
  assign c_rd_busy    = (r_state != S_IDLE);
  assign c_full       = r_full;
  assign c_empty      = r_empty;
  assign c_ovf        = r_ovf;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: drain order, full/overflow,
// read coherence (forwarding or drain-stall) and mid-read reset.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  c_wr_en;
  logic [31:0] c_wr_addr;
  logic [63:0] c_wr_data;
  logic        c_rd_en;
  logic [31:0] c_rd_addr;
  logic [63:0] c_rd_data;
  logic        c_rd_valid;
  logic        c_rd_busy;
  logic        c_full;
  logic        c_empty;
  logic        c_ovf;
  logic [7:0]  m_wren;
  logic [31:0] m_wraddress;
  logic [63:0] m_write_data;
  logic        m_rden;
  logic [31:0] m_rdaddress;
  logic [63:0] m_read_data = '0;

  logic [63:0] mem [512];
  int n_checks = 0;
  int n_errors = 0;

`ifdef WB_FWD_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 4;
`endif

  write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr),
    .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid),
    .c_rd_busy(c_rd_busy), .c_full(c_full), .c_empty(c_empty),
    .c_ovf(c_ovf), .m_wren(m_wren), .m_wraddress(m_wraddress),
    .m_write_data(m_write_data), .m_rden(m_rden),
    .m_rdaddress(m_rdaddress), .m_read_data(m_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_rden) m_read_data <= mem[m_rdaddress[11:3]];
    for (int b = 0; b < 8; b++)
      if (m_wren[b])
        mem[m_wraddress[11:3]][8*b +: 8] <= m_write_data[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    c_wr_en   = '0;
    c_wr_addr = '0;
    c_wr_data = '0;
    c_rd_en   = 1'b0;
    c_rd_addr = '0;
  endtask

  task automatic wr(input logic [7:0] be, input logic [31:0] a,
                    input logic [63:0] d);
    c_wr_en   = be;
    c_wr_addr = a;
    c_wr_data = d;
  endtask

  task automatic rd(input logic [31:0] a);
    c_rd_en   = 1'b1;
    c_rd_addr = a;
  endtask

  task automatic wait_rd(output int lat, output logic [63:0] d);
    lat = -1;
    d   = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (c_rd_valid) begin
        lat = k;
        d   = c_rd_data;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!c_empty && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(c_empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    int          lat;
    logic [63:0] d;
    bit          done;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9'h008] = 64'h1122334455667788;
    quiet();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_wren", 64'(m_wren), 64'd0);
    chk("rst_rden", 64'(m_rden), 64'd0);
    step();
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_empty", 64'(c_empty), 64'd1);
      chk("idle_full", 64'(c_full), 64'd0);
      chk("idle_wren", 64'(m_wren), 64'd0);
      chk("idle_valid", 64'(c_rd_valid), 64'd0);
      chk("idle_busy", 64'(c_rd_busy), 64'd0);
      chk("idle_ovf", 64'(c_ovf), 64'd0);
      step();
    end

    for (int k = 0; k < 6; k++) begin
      quiet();
      if (k < 4) wr(8'hFF, 32'(8 * k), 64'h1000 + 64'(k));
      @(negedge clk);
      chk("b2b_full", 64'(c_full), 64'd0);
      if (k >= 1 && k <= 4) begin
        chk("b2b_wren", 64'(m_wren), 64'hFF);
        chk("b2b_addr", 64'(m_wraddress), 64'(8 * (k - 1)));
        chk("b2b_data", m_write_data, 64'h1000 + 64'(k - 1));
      end else begin
        chk("b2b_nowr", 64'(m_wren), 64'd0);
      end
      step();
    end
    chk("b2b_empty", 64'(c_empty), 64'd1);

    for (int k = 0; k < 9; k++) begin
      quiet();
      wr(8'hFF, 32'h100 + 32'(8 * k), 64'(k));
      if (k % 3 == 0) rd(32'h800);
      @(negedge clk);
      if (m_wren != 0) q.push_back(m_wraddress);
      if (k == 1) chk("stall_rden", 64'(m_rden), 64'd1);
      if (k == 1) chk("stall_issue_nowr", 64'(m_wren), 64'd0);
      if (k == 2) chk("stall_rdval", 64'(c_rd_valid), 64'd1);
      if (k == 7) chk("stall_full3", 64'(c_full), 64'd0);
      if (k == 8) chk("stall_full4", 64'(c_full), 64'd1);
      if (k == 8) chk("stall_ovf0", 64'(c_ovf), 64'd0);
      step();
    end
    quiet();
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (t == 0) chk("ovf_set", 64'(c_ovf), 64'd1);
      if (c_empty) done = 1'b1;
      else if (m_wren != 0) q.push_back(m_wraddress);
      step();
    end
    chk("drain_done", 64'(done), 64'd1);
    chk("drain_cnt", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8 && i < q.size(); i++)
      chk("drain_order", 64'(q[i]), 64'h100 + 64'(8 * i));
    chk("mem_last", mem[9'h027], 64'd7);
    chk("mem_drop", mem[9'h028], 64'd0);
    chk("ovf_sticky", 64'(c_ovf), 64'd1);

    wr(8'h0F, 32'h40, 64'h00000000AAAAAAAA);
    rd(32'h40);
    step();
    quiet();
    wait_rd(lat, d);
    chk("merge_lat", 64'(lat), 64'(RD_LAT));
    chk("merge_data", d, 64'h11223344AAAAAAAA);
    @(negedge clk);
    chk("valid_pulse", 64'(c_rd_valid), 64'd0);
    chk("busy_clear", 64'(c_rd_busy), 64'd0);
    wait_empty("merge_empty");

    wr(8'h01, 32'h80, 64'h11);
    step();
    wr(8'h01, 32'h80, 64'h22);
    rd(32'h80);
    step();
    quiet();
    wait_rd(lat, d);
    chk("newest_lat", 64'(lat), 64'(RD_LAT));
    chk("newest_data", d, 64'h22);
    wait_empty("newest_empty");

    for (int k = 0; k < 6; k++) begin
      quiet();
      if (k < 5) wr(8'hFF, 32'h200 + 32'(8 * k), 64'hC0 + 64'(k));
      if (k == 0 || k == 3) rd(32'h900);
      if (k == 5) rst = 1'b1;
      @(negedge clk);
      if (k == 5) begin
        chk("rstw_busy", 64'(c_rd_busy), 64'd1);
        chk("rstw_notempty", 64'(c_empty), 64'd0);
        chk("rstw_nowr", 64'(m_wren), 64'd0);
      end
      step();
    end
    rst = 1'b0;
    quiet();
    @(negedge clk);
    chk("post_valid", 64'(c_rd_valid), 64'd0);
    chk("post_empty", 64'(c_empty), 64'd1);
    chk("post_wren", 64'(m_wren), 64'd0);
    chk("post_busy", 64'(c_rd_busy), 64'd0);
    chk("post_ovf", 64'(c_ovf), 64'd0);
    step();
    step();
    chk("post_mem0", mem[9'h040], 64'hC0);
    chk("post_mem2", mem[9'h042], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
